// File: rtl/clock_time_setter_if.sv
// Front-panel bus between the debounced buttons, the live time counters and
// the time-setting controller.
interface clock_time_setter_if;
   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic [5:0] cur_hours;
   logic [5:0] cur_minutes;
   logic [5:0] cur_seconds;
   logic [1:0] mode;
   logic [5:0] value;
   logic       load;
   logic       run_enable;

   modport slave (
      input  btn_mode, btn_up, btn_down,
      input  cur_hours, cur_minutes, cur_seconds,
      output mode, value, load, run_enable
   );

   modport master (
      output btn_mode, btn_up, btn_down,
      output cur_hours, cur_minutes, cur_seconds,
      input  mode, value, load, run_enable
   );
endinterface

// File: rtl/clock_time_setter.sv
// Time-setting controller: turns button edges into load/mode/value strobes for
// the hours/minutes/seconds counters and freezes them while a field is edited.
module clock_time_setter #(
   parameter int HOURS_MAX  = 24,
   parameter int MINSEC_MAX = 60,
   parameter int TIMEOUT    = 1000
) (
   input logic                Clk,
   input logic                Clr,
   clock_time_setter_if.slave bus
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_SEC  = 2'd1,
      S_MIN  = 2'd2,
      S_HOUR = 2'd3
   } state_t;

   localparam logic [6:0] HMAX = 7'(HOURS_MAX);
   localparam logic [6:0] MMAX = 7'(MINSEC_MAX);
   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [5:0]        edit_q, edit_d;
   logic              load_q, load_d;
   logic              run_en_q, run_en_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              hist_mode_q, hist_up_q, hist_dn_q;

   logic              mode_edge, up_edge, dn_edge, timeout_hit;
   logic [6:0]        field_max;

   // Out-of-range counter values are never shown; the field starts at 0 instead.
   function automatic logic [5:0] clamp_field(input logic [5:0] v, input logic [6:0] m);
      return ({1'b0, v} >= m) ? 6'd0 : v;
   endfunction

   function automatic logic [5:0] inc_wrap(input logic [5:0] e, input logic [6:0] m);
      logic [6:0] n;
      n = {1'b0, e} + 7'd1;
      return (n >= m) ? 6'd0 : n[5:0];
   endfunction

   function automatic logic [5:0] dec_wrap(input logic [5:0] e, input logic [6:0] m);
      logic [6:0] top;
      top = m - 7'd1;
      return (e == 6'd0) ? top[5:0] : e - 6'd1;
   endfunction

   assign mode_edge   = bus.btn_mode & ~hist_mode_q;
   assign up_edge     = bus.btn_up   & ~hist_up_q;
   assign dn_edge     = bus.btn_down & ~hist_dn_q;
   assign field_max   = (state_q == S_HOUR) ? HMAX : MMAX;
   assign timeout_hit = (TIMEOUT != 0) && (state_q != S_RUN) && (idle_q == TIMEOUT_C);

   always_comb begin
      state_d = state_q;
      edit_d  = edit_q;
      load_d  = 1'b0;
      idle_d  = idle_q;

      if (mode_edge) begin
         // Mode has priority; any up/down edge in the same cycle is dropped.
         idle_d = '0;
         case (state_q)
            S_RUN: begin
               state_d = S_HOUR;
               edit_d  = clamp_field(bus.cur_hours, HMAX);
            end
            S_HOUR: begin
               state_d = S_MIN;
               edit_d  = clamp_field(bus.cur_minutes, MMAX);
            end
            S_MIN: begin
               state_d = S_SEC;
               edit_d  = clamp_field(bus.cur_seconds, MMAX);
            end
            default: begin
               state_d = S_RUN;
               edit_d  = 6'd0;
            end
         endcase
      end else if (timeout_hit) begin
         state_d = S_RUN;
         edit_d  = 6'd0;
         idle_d  = '0;
      end else if (state_q != S_RUN) begin
         if (up_edge && !dn_edge) begin
            edit_d = inc_wrap(edit_q, field_max);
            load_d = 1'b1;
            idle_d = '0;
         end else if (dn_edge && !up_edge) begin
            edit_d = dec_wrap(edit_q, field_max);
            load_d = 1'b1;
            idle_d = '0;
         end else if (up_edge && dn_edge) begin
            idle_d = '0;
         end else if (idle_q != TIMEOUT_C) begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end else begin
         idle_d = '0;
      end

      run_en_d = (state_d == S_RUN);
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q     <= S_RUN;
         edit_q      <= 6'd0;
         load_q      <= 1'b0;
         run_en_q    <= 1'b1;
         idle_q      <= '0;
         // History starts high so a button held through reset is not an edge.
         hist_mode_q <= 1'b1;
         hist_up_q   <= 1'b1;
         hist_dn_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         edit_q      <= edit_d;
         load_q      <= load_d;
         run_en_q    <= run_en_d;
         idle_q      <= idle_d;
         hist_mode_q <= bus.btn_mode;
         hist_up_q   <= bus.btn_up;
         hist_dn_q   <= bus.btn_down;
      end
   end

   assign bus.mode       = state_q;
   assign bus.value      = (state_q == S_RUN) ? 6'd0 : edit_q;
   assign bus.load       = load_q;
   assign bus.run_enable = run_en_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Directed bench for clock_time_setter: default instance plus a short-timeout
// instance sharing clock and reset.
module tb_clock_time_setter;
   logic Clk = 1'b0;
   logic Clr;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 Clk = ~Clk;

   clock_time_setter_if bus ();
   clock_time_setter_if bus8 ();

   clock_time_setter dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   clock_time_setter #(.TIMEOUT(8)) dut8 (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int m, input int v, input int l, input int r);
      chk({tag, ".mode"},       32'(bus.mode),       32'(m));
      chk({tag, ".value"},      32'(bus.value),      32'(v));
      chk({tag, ".load"},       32'(bus.load),       32'(l));
      chk({tag, ".run_enable"}, 32'(bus.run_enable), 32'(r));
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int loads;
      bit found;

      Clr = 1'b0;
      bus.btn_mode = 1'b1;  bus.btn_up = 1'b0;  bus.btn_down = 1'b0;
      bus.cur_hours = 6'd23; bus.cur_minutes = 6'd0; bus.cur_seconds = 6'd45;
      bus8.btn_mode = 1'b1; bus8.btn_up = 1'b0; bus8.btn_down = 1'b0;
      bus8.cur_hours = 6'd10; bus8.cur_minutes = 6'd0; bus8.cur_seconds = 6'd0;
      repeat (3) tick;
      chk_out("rst", 0, 0, 0, 1);

      // Mode held through reset release must not count as an edge.
      Clr = 1'b1;
      repeat (5) tick;
      chk_out("held_mode", 0, 0, 0, 1);
      bus.btn_mode = 1'b0;
      bus8.btn_mode = 1'b0;
      tick;

      // SET_HOUR entry with 23, up wraps to 0.
      bus.btn_mode = 1'b1;
      tick;
      chk_out("hour_entry", 3, 23, 0, 0);
      bus.btn_mode = 1'b0;
      bus.btn_up = 1'b1;
      tick;
      chk_out("hour_up", 3, 0, 1, 0);
      tick;
      chk_out("hour_up_1cyc", 3, 0, 0, 0);
      bus.btn_up = 1'b0;
      tick;

      // SET_MIN: down from 0 wraps to 59, then back-to-back up.
      bus.btn_mode = 1'b1;
      tick;
      chk_out("min_entry", 2, 0, 0, 0);
      bus.btn_mode = 1'b0;
      bus.btn_down = 1'b1;
      tick;
      chk_out("min_down", 2, 59, 1, 0);
      bus.btn_down = 1'b0;
      bus.btn_up = 1'b1;
      tick;
      chk_out("min_up_b2b", 2, 0, 1, 0);
      bus.btn_up = 1'b0;
      tick;
      chk_out("min_idle", 2, 0, 0, 0);

      // SET_SEC: simultaneous up/down ignored; mode beats up.
      bus.btn_mode = 1'b1;
      tick;
      chk_out("sec_entry", 1, 45, 0, 0);
      bus.btn_mode = 1'b0;
      bus.btn_up = 1'b1;
      bus.btn_down = 1'b1;
      tick;
      chk_out("sec_updn", 1, 45, 0, 0);
      bus.btn_up = 1'b0;
      bus.btn_down = 1'b0;
      tick;
      bus.btn_mode = 1'b1;
      bus.btn_up = 1'b1;
      tick;
      chk_out("mode_wins", 0, 0, 0, 1);
      bus.btn_mode = 1'b0;
      bus.btn_up = 1'b0;
      tick;

      // RUN ignores up/down.
      bus.btn_up = 1'b1;
      tick;
      chk_out("run_up", 0, 0, 0, 1);
      bus.btn_up = 1'b0;
      bus.btn_down = 1'b1;
      tick;
      chk_out("run_down", 0, 0, 0, 1);
      bus.btn_down = 1'b0;
      tick;

      // Out-of-range hours capture as 0; down then wraps to 23.
      bus.cur_hours = 6'd30;
      bus.btn_mode = 1'b1;
      tick;
      chk_out("hour_clamp", 3, 0, 0, 0);
      bus.btn_mode = 1'b0;
      bus.btn_down = 1'b1;
      tick;
      chk_out("hour_down_wrap", 3, 23, 1, 0);
      bus.btn_down = 1'b0;
      tick;
      for (int i = 0; i < 3; i++) begin
         bus.btn_mode = 1'b1;
         tick;
         bus.btn_mode = 1'b0;
         tick;
      end
      chk_out("back_to_run", 0, 0, 0, 1);

      // Timeout instance: SET_HOUR with no further presses returns to RUN.
      loads = 0;
      bus8.btn_mode = 1'b1;
      tick;
      chk("to.entry_mode", 32'(bus8.mode), 32'd3);
      chk("to.entry_value", 32'(bus8.value), 32'd10);
      bus8.btn_mode = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick;
         loads += int'(bus8.load);
      end
      chk("to.still_set", 32'(bus8.mode), 32'd3);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         tick;
         loads += int'(bus8.load);
         if (bus8.mode == 2'd0) found = 1'b1;
      end
      chk("to.returned", 32'(found), 32'd1);
      chk("to.run_enable", 32'(bus8.run_enable), 32'd1);
      chk("to.no_load", 32'(loads), 32'd0);

      // Reset coinciding with an up edge in SET_MIN drops the load.
      bus.cur_minutes = 6'd17;
      bus.btn_mode = 1'b1;
      tick;
      bus.btn_mode = 1'b0;
      tick;
      bus.btn_mode = 1'b1;
      tick;
      chk_out("pre_rst_min", 2, 17, 0, 0);
      bus.btn_mode = 1'b0;
      tick;
      loads = 0;
      bus.btn_up = 1'b1;
      Clr = 1'b0;
      #1;
      chk_out("async_rst", 0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         tick;
         loads += int'(bus.load);
      end
      Clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         loads += int'(bus.load);
      end
      chk_out("post_rst", 0, 0, 0, 1);
      chk("rst_no_load", 32'(loads), 32'd0);
      bus.btn_up = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Front-panel time-setting controller for the clock.
- Converts button presses into the load/mode/value bus consumed by the hours, minutes and seconds counters. The hours counter loads when mode=3.
- Gates counter Enable while the user is editing.
- Sits between the debounced button block and the three time counters; it writes the values the counters read.

Parameters:
- HOURS_MAX, 24, hours field modulus (legal 2..64)
- MINSEC_MAX, 60, minutes/seconds field modulus (legal 2..64)
- TIMEOUT, 1000, idle Clk cycles in a set state before auto-return to RUN; 0 disables

Ports:
- Clk  input  1  system clock, rising edge
- Clr  input  1  asynchronous active-low reset
- btn_mode  input  1  debounced, synchronous level; rising edge advances state
- btn_up  input  1  debounced level; rising edge increments field
- btn_down  input  1  debounced level; rising edge decrements field
- cur_hours  input  6  live hours counter Q
- cur_minutes  input  6  live minutes counter Q
- cur_seconds  input  6  live seconds counter Q
- mode  output  2  0=RUN, 1=SET_SEC, 2=SET_MIN, 3=SET_HOUR
- value  output  6  field value to load
- load  output  1  one-cycle load strobe to counters
- run_enable  output  1  AND-ed into counter Enable; low while setting

Behaviour:

Reset (Clr=0, async):
- Outputs: state RUN, mode=0, value=0, load=0, run_enable=1, edit=0, idle counter=0.
- Button history registers reset to 1, so a button held through reset release gives no edge until released and pressed again.
- Reset mid-edit drops any pending load; no partial value reaches the counters.

Edge detection:
- Edge on a button = sampled high at a Clk rise with history low.
- History updates every Clk rise.

State sequence on mode edge: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
- mode and run_enable are registered state decodes and change on the same edge as state.
- On entering a set state, edit captures the matching cur_* value. If the captured value is >= that field's modulus, edit captures 0.
- value = edit in set states and 0 in RUN.
- No load is issued on entry or on exit.

Field editing (set states only):
- up edge: edit <= (edit+1 >= MAX) ? 0 : edit+1.
- down edge: edit <= (edit==0) ? MAX-1 : edit-1.
- MAX is HOURS_MAX in SET_HOUR and MINSEC_MAX otherwise.
- At the same Clk rise that registers the new edit, load is asserted for exactly one cycle with value=new edit and mode=current state code.
- Consecutive edges on consecutive cycles produce back-to-back loads, one per edge.

Simultaneous events:
- up and down edges in the same cycle: both ignored (no change, no load).
- mode edge together with up/down edge: mode wins; up/down dropped.

Other rules:
- In RUN, up and down are ignored; load stays 0.
- Timeout: the idle counter clears on any button edge and on state change. It increments each cycle in a set state. When it reaches TIMEOUT, state returns to RUN next cycle, with no load. The idle counter is not used in RUN.
- Arithmetic is 6-bit unsigned. Moduli are compared as integers; no overflow past 63 is possible.

Test Plan:
1. Reset held with btn_mode=1, release, hold 5 cycles -> mode=0, load=0, run_enable=1, no state change.
2. cur_hours=23, mode edge -> mode=3, value=23, run_enable=0. Up edge -> value=0, load high exactly 1 cycle with mode=3.
3. SET_MIN with cur_minutes=0, down edge -> value=59, one load with mode=2. Up edge next cycle -> value=0, second load.
4. In SET_SEC, up and down rise in the same cycle -> value unchanged, load=0. Mode and up in the same cycle -> mode=0, load=0, run_enable=1.
5. TIMEOUT=8, enter SET_HOUR with no further presses -> mode=0 and run_enable=1 after 8 cycles; no load at any point.
6. Assert Clr in the same cycle as an up edge in SET_MIN -> load never asserts; all outputs at reset values.
